// File: rtl/ttt_seq_pkg.sv
// Shared types and constants for the tick sequencer: FSM states, default
// widths and the core's start/stop flag encoding.
package ttt_seq_pkg;

    localparam int ID_BITS     = 4;
    localparam int TOKENS_BITS = 8;

    localparam logic [1:0] SS_IDLE  = 2'b00;
    localparam logic [1:0] SS_START = 2'b01;
    localparam logic [1:0] SS_STOP  = 2'b10;
    localparam logic [1:0] SS_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/ttt_tick_divider.sv
// Tick period counter: pulses tick_due once every tick_period clocks while
// enabled; a zero period or ena=0 parks the counter at tick_period.
module ttt_tick_divider #(
    parameter int PERIOD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [PERIOD_BITS-1:0] tick_period,
    output logic                   tick_due
);

    logic [PERIOD_BITS-1:0] cnt_q;
    logic [PERIOD_BITS-1:0] cnt_d;
    logic                   running;

    assign running  = ena && (tick_period != '0);
    assign tick_due = running && (cnt_q == PERIOD_BITS'(1));

    // A count of 0 only exists after reset, so it reloads like the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (!running) begin
            cnt_d = tick_period;
        end else if (cnt_q <= PERIOD_BITS'(1)) begin
            cnt_d = tick_period;
        end else begin
            cnt_d = cnt_q - PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ticktocktokens_sequencer.sv
// Tick sequencer for the token-processor core: load tokens, run one evaluation,
// drain start/stop flags. Define TTT_SKIP_IDLE_EN to drop all-zero results.
module ticktocktokens_sequencer #(
    parameter int NUM_PROCESSORS = 10,
    parameter int ID_BITS        = ttt_seq_pkg::ID_BITS,
    parameter int TOKENS_BITS    = ttt_seq_pkg::TOKENS_BITS,
    parameter int PERIOD_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [PERIOD_BITS-1:0] tick_period,
    input  logic                   clr_overrun,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOKENS_BITS-1:0] in_tokens,
    output logic [ID_BITS-1:0]     core_processor_id,
    output logic [TOKENS_BITS-1:0] core_tokens_in,
    output logic                   core_tokens_valid,
    output logic                   core_hold,
    output logic                   core_tick,
    input  logic                   core_done,
    input  logic [1:0]             core_startstop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_BITS-1:0]     out_id,
    output logic [1:0]             out_startstop,
    output logic                   busy,
    output logic                   overrun
);

    import ttt_seq_pkg::*;

    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);

    state_e                 state_q, state_d;
    logic [ID_BITS-1:0]     idx_q, idx_d;
    logic [ID_BITS-1:0]     pid_q, pid_d;
    logic [TOKENS_BITS-1:0] tok_q, tok_d;
    logic                   tv_q, tv_d;
    logic                   tick_q, tick_d;
    logic                   ov_q, ov_d;
    logic [ID_BITS-1:0]     oid_q, oid_d;
    logic [1:0]             oss_q, oss_d;
    logic                   overrun_q, overrun_d;
    logic                   tick_due;
    logic                   skip;
    logic                   can_cap;

    ttt_tick_divider #(
        .PERIOD_BITS(PERIOD_BITS)
    ) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .tick_period(tick_period),
        .tick_due   (tick_due)
    );

    // During DRAIN the core is addressed straight from idx so its combinational
    // flags can be captured in the same cycle.
    assign core_processor_id = (state_q == DRAIN) ? idx_q : pid_q;
    assign core_tokens_in    = tok_q;
    assign core_tokens_valid = tv_q;
    assign core_hold         = (state_q != RUN);
    assign core_tick         = tick_q;
    assign in_ready          = (state_q == LOAD);
    assign out_valid         = ov_q;
    assign out_id            = oid_q;
    assign out_startstop     = oss_q;
    assign busy              = (state_q != IDLE);
    assign overrun           = overrun_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pid_d     = pid_q;
        tok_d     = tok_q;
        tv_d      = 1'b0;
        tick_d    = 1'b0;
        oid_d     = oid_q;
        oss_d     = oss_q;
        ov_d      = ov_q && !out_ready;
        overrun_d = overrun_q;
        can_cap   = !ov_q || out_ready;
`ifdef TTT_SKIP_IDLE_EN
        skip      = (core_startstop == SS_IDLE);
`else
        skip      = 1'b0;
`endif

        // A set in the same cycle as a clear must win, hence the ordering.
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (tick_due && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tick_due) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    pid_d = idx_q;
                    tok_d = in_tokens;
                    tv_d  = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_ID) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                tick_d  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (core_done && !tick_q) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (skip || can_cap) begin
                    if (!skip) begin
                        ov_d  = 1'b1;
                        oid_d = idx_q;
                        oss_d = core_startstop;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_ID) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pid_q     <= '0;
            tok_q     <= '0;
            tv_q      <= 1'b0;
            tick_q    <= 1'b0;
            ov_q      <= 1'b0;
            oid_q     <= '0;
            oss_q     <= 2'b00;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pid_q     <= pid_d;
            tok_q     <= tok_d;
            tv_q      <= tv_d;
            tick_q    <= tick_d;
            ov_q      <= ov_d;
            oid_q     <= oid_d;
            oss_q     <= oss_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_ticktocktokens_sequencer.sv
// Bench for ticktocktokens_sequencer: scenario table with a token/result
// scoreboard, plus hand sequences for overrun and reset during RUN.
module tb_ticktocktokens_sequencer;

    localparam int N = 10;
`ifdef TTT_SKIP_IDLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int RES   = SKIP ? 2 : N;
    localparam int FIRST = SKIP ? 5 : 2;
    localparam int HELD  = SKIP ? 0 : 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] tick_period;
    logic        clr_overrun;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_tokens;
    logic [3:0]  core_processor_id;
    logic [7:0]  core_tokens_in;
    logic        core_tokens_valid;
    logic        core_hold;
    logic        core_tick;
    logic        core_done = 1'b0;
    logic [1:0]  core_startstop;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_id;
    logic [1:0]  out_startstop;
    logic        busy;
    logic        overrun;

    typedef struct {
        int id;
        int val;
    } item_t;

    typedef struct {
        int stallIdx;
        int stallLen;
        int bpId;
        int bpLen;
        int doneDly;
        int earlyDone;
        int base;
        int expStrobes;
        int expResults;
        int expGap;
        int expHoldLow;
        int expHeld;
        int expFirstOut;
    } vec_t;

    item_t  tokQ[$];
    item_t  resQ[$];
    vec_t   vecs[4];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     strobes = 0, results = 0, maxGap = 0, holdLow = 0, held = 0;
    longint lastStrobeCyc = -1, doneCyc = -1, firstOutCyc = -1;
    int     doneCnt = 0, doneDly = 5, earlyDone = 0, bpId = -1, bpLeft = 0;
    logic   heldPrev = 1'b0;
    logic [3:0] heldId = '0;

    ticktocktokens_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ena              (ena),
        .tick_period      (tick_period),
        .clr_overrun      (clr_overrun),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_tokens        (in_tokens),
        .core_processor_id(core_processor_id),
        .core_tokens_in   (core_tokens_in),
        .core_tokens_valid(core_tokens_valid),
        .core_hold        (core_hold),
        .core_tick        (core_tick),
        .core_done        (core_done),
        .core_startstop   (core_startstop),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_id           (out_id),
        .out_startstop    (out_startstop),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] ssModel(input logic [3:0] id);
`ifdef TTT_SKIP_IDLE_EN
        if (id == 4'd3) return 2'b01;
        if (id == 4'd7) return 2'b10;
        return 2'b00;
`else
        return 2'((int'(id) * 3 + 1) % 4);
`endif
    endfunction

    assign core_startstop = ssModel(core_processor_id);

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Core model, output sink and scoreboard, all sampled on the falling edge.
    always @(negedge clk) begin
        item_t e;
        if (!rst_n) begin
            doneCnt   = 0;
            core_done = 1'b0;
            out_ready = 1'b1;
            heldPrev  = 1'b0;
        end else begin
            if (core_tick) begin
                doneCnt   = doneDly;
                core_done = (earlyDone != 0);
            end else if (doneCnt > 0) begin
                doneCnt--;
                core_done = (doneCnt == 0);
            end else begin
                core_done = 1'b0;
            end

            if (bpLeft > 0 && out_valid && int'(out_id) == bpId) begin
                out_ready = 1'b0;
                bpLeft--;
            end else begin
                out_ready = 1'b1;
            end

            if (!core_hold) holdLow++;
            if (core_done && !core_tick && !core_hold && doneCyc < 0) doneCyc = cyc;
            if (out_valid && firstOutCyc < 0) firstOutCyc = cyc;

            if (core_tokens_valid) begin
                strobes++;
                if (lastStrobeCyc >= 0 && int'(cyc - lastStrobeCyc - 1) > maxGap)
                    maxGap = int'(cyc - lastStrobeCyc - 1);
                lastStrobeCyc = cyc;
                if (tokQ.size() == 0) begin
                    checkOutput("token_strobe_expected", 1, 0);
                end else begin
                    e = tokQ.pop_front();
                    checkOutput("token_id", longint'(core_processor_id), e.id);
                    checkOutput("token_value", longint'(core_tokens_in), e.val);
                end
            end

            if (core_tick) begin
                checkOutput("tick_after_last_strobe", cyc - lastStrobeCyc, 1);
                for (int id = 0; id < N; id++) begin
                    if (!SKIP || ssModel(4'(id)) != 2'b00) begin
                        e.id  = id;
                        e.val = int'(ssModel(4'(id)));
                        resQ.push_back(e);
                    end
                end
            end

            if (out_valid && !out_ready) begin
                held++;
                if (heldPrev) checkOutput("held_out_id", longint'(out_id), longint'(heldId));
                heldPrev = 1'b1;
                heldId   = out_id;
            end else begin
                heldPrev = 1'b0;
            end

            if (out_valid && out_ready) begin
                results++;
                if (resQ.size() == 0) begin
                    checkOutput("result_expected", 1, 0);
                end else begin
                    e = resQ.pop_front();
                    checkOutput("result_id", longint'(out_id), e.id);
                    checkOutput("result_startstop", longint'(out_startstop), e.val);
                end
            end
        end
    end

    task automatic loadTokens(input int stallIdx, input int stallLen, input int base);
        int i = 0;
        int stalled = 0;
        int guard = 0;
        item_t e;
        while (i < N && guard < 400) begin
            @(negedge clk);
            guard++;
            if (i == stallIdx && stalled < stallLen) begin
                in_valid = 1'b0;
                stalled++;
            end else begin
                in_valid  = 1'b1;
                in_tokens = 8'(base + i);
                if (in_ready) begin
                    e.id  = i;
                    e.val = (base + i) % 256;
                    tokQ.push_back(e);
                    i++;
                end
            end
        end
        if (i < N) checkOutput("load_completed", i, N);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        int g;
        strobes = 0; results = 0; maxGap = 0; holdLow = 0; held = 0;
        lastStrobeCyc = -1; doneCyc = -1; firstOutCyc = -1;
        doneDly = v.doneDly; earlyDone = v.earlyDone; bpId = v.bpId; bpLeft = v.bpLen;
        g = 0;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        checkOutput("tick_started", longint'(in_ready), 1);
        if (!in_ready) return;
        loadTokens(v.stallIdx, v.stallLen, v.base);
        g = 0;
        while ((busy || out_valid) && g < 400) begin
            @(negedge clk);
            g++;
        end
        checkOutput("drain_finished", longint'(busy || out_valid), 0);
        checkOutput("strobe_count", strobes, v.expStrobes);
        checkOutput("result_count", results, v.expResults);
        checkOutput("strobe_gap", maxGap, v.expGap);
        checkOutput("hold_low_cycles", holdLow, v.expHoldLow);
        checkOutput("held_cycles", held, v.expHeld);
        checkOutput("done_to_first_out", firstOutCyc - doneCyc, v.expFirstOut);
        checkOutput("token_queue_empty", tokQ.size(), 0);
        checkOutput("result_queue_empty", resQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int cnt;
        logic sawBusy;
        rst_n = 1'b0; ena = 1'b0; tick_period = 16'd100;
        in_valid = 1'b0; in_tokens = '0; clr_overrun = 1'b0;

        vecs[0] = '{-1, 0, -1, 0, 5, 0,  1, N, RES, 0, 6, 0,    FIRST};
        vecs[1] = '{ 4, 3, -1, 0, 5, 0, 17, N, RES, 3, 6, 0,    FIRST};
        vecs[2] = '{-1, 0,  2, 4, 5, 0, 33, N, RES, 0, 6, HELD, FIRST};
        vecs[3] = '{-1, 0, -1, 0, 2, 1, 49, N, RES, 0, 3, 0,    FIRST};

        repeat (3) @(negedge clk);
        checkOutput("reset_core_hold", longint'(core_hold), 1);
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_in_ready", longint'(in_ready), 0);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_core_tick", longint'(core_tick), 0);
        checkOutput("reset_tokens_valid", longint'(core_tokens_valid), 0);
        checkOutput("reset_overrun", longint'(overrun), 0);
        rst_n = 1'b1;

        sawBusy = 1'b0;
        repeat (120) begin
            @(negedge clk);
            sawBusy |= busy;
        end
        checkOutput("no_tick_when_disabled", longint'(sawBusy), 0);
        ena = 1'b1;

        for (int k = 0; k < 4; k++) applyStimulus(vecs[k]);

        // Overrun: short period, no tokens supplied, so the second tick lands in LOAD.
        @(negedge clk);
        ena = 1'b0;
        tick_period = 16'd5;
        @(negedge clk);
        ena = 1'b1;
        g = 0;
        while (!busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        cnt = 0;
        while (!overrun && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("overrun_delay", cnt, 5);
        checkOutput("busy_at_overrun", longint'(busy), 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checkOutput("overrun_cleared", longint'(overrun), 0);
        checkOutput("busy_after_clear", longint'(busy), 1);

        // Reset asserted while the core is running.
        tick_period = 16'd100;
        doneDly = 50; earlyDone = 0; bpLeft = 0;
        loadTokens(-1, 0, 200);
        g = 0;
        while (core_hold && g < 20) begin
            @(negedge clk);
            g++;
        end
        checkOutput("entered_run", longint'(core_hold), 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_core_hold", longint'(core_hold), 1);
        checkOutput("async_reset_busy", longint'(busy), 0);
        checkOutput("async_reset_out_valid", longint'(out_valid), 0);
        checkOutput("async_reset_overrun", longint'(overrun), 0);
        checkOutput("async_reset_core_tick", longint'(core_tick), 0);
        resQ.delete();
        tokQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        doneDly = 5;

        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ticktocktokens_sequencer.md
# ticktocktokens_sequencer

Tick sequencer for the token-processor core. Each tick period it streams one token count per processor into the core, releases the core for one evaluation, waits for `done`, then reads back every processor's start/stop flags as an output stream. It sits between the chip I/O and the core, and replaces the constant `hold`/`clock_slow` ties with real sequencing.

## Interface
- `NUM_PROCESSORS`, default 10: processors addressed per tick.
- `ID_BITS`, default 4: width of processor id; must satisfy 2^ID_BITS ≥ NUM_PROCESSORS.
- `TOKENS_BITS`, default 8: width of the token count.
- `PERIOD_BITS`, default 16: width of the tick period.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: enables tick generation.
- `tick_period` in PERIOD_BITS: clocks between ticks; 0 disables ticks.
- `clr_overrun` in 1: clears `overrun`.
- `in_valid` in 1 / `in_ready` out 1 / `in_tokens` in TOKENS_BITS: token input stream, one beat per processor in id order.
- `core_processor_id` out ID_BITS: processor address to the core.
- `core_tokens_in` out TOKENS_BITS: token count to the core.
- `core_tokens_valid` out 1: write strobe to the core.
- `core_hold` out 1: 1 freezes the core.
- `core_tick` out 1: one-cycle evaluation pulse.
- `core_done` in 1: core finished its evaluation.
- `core_startstop` in 2: flags of the addressed processor; combinational from `core_processor_id`.
- `out_valid` out 1 / `out_ready` in 1 / `out_id` out ID_BITS / `out_startstop` out 2: result stream.
- `busy` out 1: FSM is not in IDLE.
- `overrun` out 1: sticky; a tick arrived while busy.

## Operation
- Divider:
  - Counts down from `tick_period` while `ena`=1 and `tick_period`≠0.
  - At 1 it asserts `tick_due` for one cycle and reloads.
  - While `ena`=0 the counter is held at `tick_period`.
- IDLE:
  - On `tick_due`, `idx`←0 and go to LOAD.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` registers `core_processor_id`=idx, `core_tokens_in`=`in_tokens` and pulses `core_tokens_valid` on the next cycle, then idx++.
  - The accept with idx=NUM_PROCESSORS-1 goes to START.
- START:
  - One settle cycle; `core_hold` stays 1.
- RUN:
  - First cycle: `core_tick`=1 and `core_hold`=0.
  - `core_hold` stays 0 until `core_done` is sampled at 1; `core_done` during the tick cycle is ignored.
  - Then `core_hold`=1, idx←0, go to DRAIN.
- DRAIN:
  - `core_processor_id`=idx.
  - When `!out_valid || out_ready`: capture `out_id`=idx and `out_startstop`=`core_startstop`, set `out_valid`, idx++.
  - After the capture at idx=NUM_PROCESSORS-1, go to IDLE.
  - `out_valid` is held until accepted, including after returning to IDLE.
- `tick_due` while not in IDLE: the tick is dropped and `overrun`←1. `clr_overrun` clears it; a set in the same cycle wins.
- Reset asserted mid-sequence: immediate return to IDLE with `core_hold`=1 and any partial tick abandoned.

## Timing
- Reset values:
  - `core_hold`=1.
  - All other outputs 0.
  - Divider loaded with 0; it reloads `tick_period` on the first enabled cycle.
- `tick_due` at cycle T gives `in_ready`=1 at T+1.
- Last accept at c gives the last `core_tokens_valid` at c+1 (START) and `core_tick` at c+2.
- `core_done` sampled at d gives `core_hold`=1 and DRAIN at d+1; the first `out_valid` appears at d+2.
- Full tick with no stalls: 2N+4 cycles plus the core runtime.

## Configuration
- `TTT_SKIP_IDLE_EN` defined: DRAIN skips processors whose `core_startstop`=2'b00. A skip advances idx without asserting `out_valid`, at one cycle per skipped id.
- `TTT_SKIP_IDLE_EN` undefined: exactly NUM_PROCESSORS results per tick.

## Structure
- Package `ttt_seq_pkg`: the state enum (IDLE, LOAD, START, RUN, DRAIN), `ID_BITS`, `TOKENS_BITS` and the startstop encoding constants.
- Sub-module `ttt_tick_divider`: the period counter producing `tick_due`.

## Test plan
- Reset: drive `rst_n`=0 mid-RUN → `core_hold`=1, `busy`=0, `out_valid`=0 asynchronously.
- Nominal tick: `tick_period`=100, N=10, `in_tokens`=idx+1 with no stalls, `core_done` 5 cycles after `core_tick` → 10 token strobes with ids 0..9, one `core_tick`, results with ids 0..9 in order.
- Input stalls: deassert `in_valid` for 3 cycles at idx 4 → `core_tokens_valid` gap of 3 cycles, and the written values are unchanged.
- Output backpressure: `out_ready`=0 for 4 cycles at id 2 → `out_id` held at 2, no loss or reorder, FSM stalls in DRAIN.
- Overrun: `tick_period`=5 with `in_valid`=0 → `overrun`=1 at the second `tick_due`, `busy` stays 1; `clr_overrun` → 0.
- With `TTT_SKIP_IDLE_EN`: `core_startstop` nonzero only for ids 3 and 7 → exactly two results, ids 3 then 7.
